// File: rtl/port_fe_pkg.sv
// Shared definitions for the port write/read frontends: halfword width,
// header field positions and the read-side state encoding.
package port_fe_pkg;

    localparam int HWORD_W  = 16;
    localparam int LEN_W    = 9;
    localparam int LEN_MSB  = 15;
    localparam int LEN_LSB  = 7;
    localparam int DEST_MSB = 3;
    localparam int DEST_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOP  = 2'd1,
        DATA = 2'd2,
        EOP  = 2'd3
    } rd_state_e;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [HWORD_W-1:0] w);
        return w[LEN_MSB:LEN_LSB];
    endfunction

endpackage

// File: rtl/port_rd_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty distinction,
// registered write, combinational head read, asynchronous active-low reset.
module port_rd_fifo #(
    parameter int DEPTH_LOG2 = 6,
    parameter int WIDTH      = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/port_rd_frontend.sv
// Egress frontend: buffers backend halfwords in a FIFO and replays packets as
// rd_sop / rd_vld burst / rd_eop. Optional macro PORT_RD_LENGTH_CHECK_EN adds len_err.
module port_rd_frontend
    import port_fe_pkg::*;
#(
    parameter int DEPTH_LOG2   = 6,
    parameter int PAUSE_MARGIN = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               xfer_data_vld,
    input  logic [HWORD_W-1:0] xfer_data,
    input  logic               end_of_packet,
    output logic               xfer_pause,
    input  logic               rd_ready,
    output logic               rd_sop,
    output logic               rd_vld,
    output logic [HWORD_W-1:0] rd_data,
    output logic               rd_eop,
    output logic               ovf
`ifdef PORT_RD_LENGTH_CHECK_EN
    ,
    output logic               len_err
`endif
);

    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    rd_state_e          state;
    logic               full;
    logic               empty;
    logic [CW-1:0]      count;
    logic [CW-1:0]      free_slots;
    logic [HWORD_W:0]   head;
    logic               push;
    logic               pop;

    assign push       = xfer_data_vld && !full;
    assign pop        = (state == DATA) && rd_ready && !empty;
    assign free_slots = CW'(DEPTH) - count;

    port_rd_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (HWORD_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({end_of_packet, xfer_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

`ifdef PORT_RD_LENGTH_CHECK_EN
    logic [LEN_W-1:0] len_cnt;
    logic [LEN_W-1:0] len_hdr;
`endif

    // Framing pulses are registered from the state one cycle behind, so rd_sop
    // lands right before the first rd_vld and rd_eop right after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_sop     <= 1'b0;
            rd_vld     <= 1'b0;
            rd_data    <= '0;
            rd_eop     <= 1'b0;
            xfer_pause <= 1'b0;
            ovf        <= 1'b0;
`ifdef PORT_RD_LENGTH_CHECK_EN
            len_cnt    <= '0;
            len_hdr    <= '0;
            len_err    <= 1'b0;
`endif
        end else begin
            rd_sop     <= (state == SOP);
            rd_eop     <= (state == EOP);
            rd_vld     <= pop;
            xfer_pause <= (free_slots <= CW'(PAUSE_MARGIN));
            if (xfer_data_vld && full) ovf <= 1'b1;
            if (pop) rd_data <= head[HWORD_W-1:0];
`ifdef PORT_RD_LENGTH_CHECK_EN
            len_err <= (state == EOP) && (len_cnt != len_hdr);
            if (state == SOP) len_cnt <= '0;
            if (pop) begin
                len_cnt <= len_cnt + 1'b1;
                if (len_cnt == '0) len_hdr <= hdr_len(head[HWORD_W-1:0]);
            end
`endif
            case (state)
                IDLE: if (!empty && rd_ready) state <= SOP;
                SOP:  state <= DATA;
                DATA: if (pop && head[HWORD_W]) state <= EOP;
                EOP:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_port_rd_frontend.sv
// Self-checking bench for port_rd_frontend: queue-based reference model plus
// directed timing scenarios and randomized traffic.
module tb_port_rd_frontend;

    localparam int DEPTH        = 64;
    localparam int PAUSE_MARGIN = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        xfer_data_vld;
    logic [15:0] xfer_data;
    logic        end_of_packet;
    logic        xfer_pause;
    logic        rd_ready;
    logic        rd_sop;
    logic        rd_vld;
    logic [15:0] rd_data;
    logic        rd_eop;
    logic        ovf;
`ifdef PORT_RD_LENGTH_CHECK_EN
    logic        len_err;
`endif

    always #5 clk = ~clk;

    port_rd_frontend #(
        .DEPTH_LOG2   (6),
        .PAUSE_MARGIN (PAUSE_MARGIN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .xfer_data_vld (xfer_data_vld),
        .xfer_data     (xfer_data),
        .end_of_packet (end_of_packet),
        .xfer_pause    (xfer_pause),
        .rd_ready      (rd_ready),
        .rd_sop        (rd_sop),
        .rd_vld        (rd_vld),
        .rd_data       (rd_data),
        .rd_eop        (rd_eop),
        .ovf           (ovf)
`ifdef PORT_RD_LENGTH_CHECK_EN
        ,
        .len_err       (len_err)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: FIFO contents as a queue of {eop, data}, occupancy,
    // sticky overflow and packet framing state.
    logic [16:0] mq[$];
    int          mcount;
    logic        ovf_m;
    logic        in_pkt;
    logic        exp_eop;
    int          pkt_words;
    int          pkt_hdr;
    int          le_cnt;
    int          cyc;
    int          ready_mode;   // 0 hold, 1 toggle, 2 random
    int          sop_log[$];
    int          vld_log[$];
    int          eop_log[$];

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        mcount    = 0;
        ovf_m     = 1'b0;
        in_pkt    = 1'b0;
        exp_eop   = 1'b0;
        pkt_words = 0;
        pkt_hdr   = 0;
    endtask

    task automatic clear_logs();
        sop_log.delete();
        vld_log.delete();
        eop_log.delete();
        le_cnt = 0;
    endtask

    // One clock: observe effects of the cycle just ended, update the model.
    task automatic step();
        int          cb;
        logic [16:0] e;
        cb = mcount;
        @(posedge clk);
        #1;
        cyc++;
        chk_bit("pause", xfer_pause, (DEPTH - cb) <= PAUSE_MARGIN);
        if (xfer_data_vld && cb == DEPTH) ovf_m = 1'b1;
        chk_bit("ovf", ovf, ovf_m);
        chk_bit("eop", rd_eop, exp_eop);
`ifdef PORT_RD_LENGTH_CHECK_EN
        chk_bit("len_err", len_err, rd_eop && (pkt_words != pkt_hdr));
        if (len_err) le_cnt++;
`endif
        exp_eop = 1'b0;
        if (rd_eop) begin
            eop_log.push_back(cyc);
            in_pkt = 1'b0;
        end
        if (rd_sop) begin
            chk_bit("sop_outside_pkt", in_pkt, 1'b0);
            chk_bit("sop_no_vld", rd_vld, 1'b0);
            in_pkt    = 1'b1;
            pkt_words = 0;
            sop_log.push_back(cyc);
        end else if (rd_vld) begin
            vld_log.push_back(cyc);
            chk_bit("vld_in_pkt", in_pkt, 1'b1);
            chk_bit("vld_has_data", mq.size() > 0, 1'b1);
            if (mq.size() > 0) begin
                e = mq.pop_front();
                chk16("data", rd_data, e[15:0]);
                exp_eop = e[16];
                if (pkt_words == 0) pkt_hdr = int'(e[15:7]);
                pkt_words++;
                mcount--;
            end
        end
        if (xfer_data_vld && cb < DEPTH) begin
            mq.push_back({end_of_packet, xfer_data});
            mcount++;
        end
        case (ready_mode)
            1:       rd_ready = ~rd_ready;
            2:       rd_ready = ($urandom_range(0, 3) != 0);
            default: rd_ready = rd_ready;
        endcase
    endtask

    task automatic idle(input int n);
        xfer_data_vld = 1'b0;
        end_of_packet = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_pkt(input int len, input logic [8:0] hdr, input bit gaps);
        logic [15:0] w;
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < 200 && xfer_pause; g++) begin
                xfer_data_vld = 1'b0;
                end_of_packet = 1'b0;
                step();
            end
            w = 16'($urandom);
            if (i == 0) w = {hdr, 3'($urandom), 4'($urandom)};
            xfer_data_vld = 1'b1;
            xfer_data     = w;
            end_of_packet = (i == len - 1);
            step();
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
        end
        xfer_data_vld = 1'b0;
        end_of_packet = 1'b0;
    endtask

    task automatic drain();
        xfer_data_vld = 1'b0;
        end_of_packet = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (mcount == 0 && !in_pkt && !exp_eop) break;
            step();
        end
        chk_int("drain_left", mcount, 0);
        chk_bit("drain_framing_closed", in_pkt, 1'b0);
        idle(3);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        chk_bit("rst_sop", rd_sop, 1'b0);
        chk_bit("rst_vld", rd_vld, 1'b0);
        chk_bit("rst_eop", rd_eop, 1'b0);
        chk16("rst_data", rd_data, 16'h0000);
        chk_bit("rst_pause", xfer_pause, 1'b0);
        chk_bit("rst_ovf", ovf, 1'b0);
        model_clear();
        xfer_data_vld = 1'b0;
        end_of_packet = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pause_step;
        int ovf_step;
        int base;
        logic prev_v;

        rst_n         = 1'b1;
        xfer_data_vld = 1'b0;
        xfer_data     = '0;
        end_of_packet = 1'b0;
        rd_ready      = 1'b0;
        ready_mode    = 0;
        cyc           = 0;
        model_clear();
        clear_logs();
        #2;
        async_reset();
        idle(2);

        // 4-halfword packet with steady ready
        rd_ready = 1'b1;
        clear_logs();
        push_pkt(4, 9'd4, 1'b0);
        idle(12);
        chk_int("p4_sop_count", sop_log.size(), 1);
        chk_int("p4_vld_count", vld_log.size(), 4);
        chk_int("p4_eop_count", eop_log.size(), 1);
        if (sop_log.size() == 1 && vld_log.size() == 4 && eop_log.size() == 1) begin
            for (int i = 0; i < 4; i++)
                chk_int("p4_vld_cycle", vld_log[i], sop_log[0] + 1 + i);
            chk_int("p4_eop_cycle", eop_log[0], sop_log[0] + 5);
        end

        // Two back-to-back single-halfword packets
        clear_logs();
        push_pkt(1, 9'd1, 1'b0);
        push_pkt(1, 9'd1, 1'b0);
        idle(12);
        chk_int("b2b_sop_count", sop_log.size(), 2);
        chk_int("b2b_eop_count", eop_log.size(), 2);
        if (sop_log.size() == 2 && eop_log.size() == 2) begin
            chk_int("b2b_eop1", eop_log[0], sop_log[0] + 2);
            chk_int("b2b_sop2", sop_log[1], sop_log[0] + 4);
            chk_int("b2b_eop2", eop_log[1], sop_log[0] + 6);
        end

        // Fill with no reads: pause threshold, overflow, retention
        rd_ready   = 1'b0;
        pause_step = 0;
        ovf_step   = 0;
        for (int k = 1; k <= 70; k++) begin
            xfer_data_vld = 1'b1;
            xfer_data     = 16'($urandom);
            end_of_packet = (k == 64);
            step();
            if (xfer_pause && pause_step == 0) pause_step = k;
            if (ovf && ovf_step == 0) ovf_step = k;
        end
        chk_int("fill_pause_step", pause_step, 62);
        chk_int("fill_ovf_step", ovf_step, 65);
        clear_logs();
        rd_ready = 1'b1;
        drain();
        chk_int("fill_retained", vld_log.size(), 64);
        chk_int("fill_eop_count", eop_log.size(), 1);

        // 10-halfword packet with ready toggling every cycle
        clear_logs();
        ready_mode = 1;
        push_pkt(10, 9'd10, 1'b0);
        prev_v = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            chk_bit("toggle_no_back2back", rd_vld && prev_v, 1'b0);
            prev_v = rd_vld;
        end
        chk_int("toggle_vld_count", vld_log.size(), 10);
        chk_int("toggle_eop_count", eop_log.size(), 1);
        ready_mode = 0;
        rd_ready   = 1'b1;
        drain();

        // Randomized traffic with random ready and push gaps
        ready_mode = 2;
        for (int p = 0; p < 12; p++) begin
            int len;
            len = $urandom_range(1, 12);
            push_pkt(len, 9'(len), 1'b1);
        end
        drain();
        ready_mode = 0;
        rd_ready   = 1'b1;

        // Reset in the middle of a 20-halfword packet
        clear_logs();
        for (int i = 0; i < 20 && vld_log.size() < 5; i++) begin
            xfer_data_vld = 1'b1;
            xfer_data     = (i == 0) ? 16'(20 << 7) : 16'($urandom);
            end_of_packet = (i == 19);
            step();
        end
        xfer_data_vld = 1'b0;
        end_of_packet = 1'b0;
        chk_int("rst_mid_started", (vld_log.size() >= 5) ? 1 : 0, 1);
        #2;
        async_reset();
        clear_logs();
        idle(12);
        chk_int("post_rst_vld", vld_log.size(), 0);
        chk_int("post_rst_eop", eop_log.size(), 0);
        chk_int("post_rst_sop", sop_log.size(), 0);

        // Wrap-safe framing after reset
        clear_logs();
        push_pkt(3, 9'd3, 1'b0);
        drain();
        chk_int("post_rst_pkt_vld", vld_log.size(), 3);

`ifdef PORT_RD_LENGTH_CHECK_EN
        clear_logs();
        push_pkt(6, 9'd5, 1'b0);
        drain();
        chk_int("len_err_mismatch", le_cnt, 1);
        clear_logs();
        push_pkt(6, 9'd6, 1'b0);
        drain();
        chk_int("len_err_match", le_cnt, 0);
`endif

        base = cyc;
        chk_int("cycle_budget_ok", (base < 20000) ? 1 : 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
